// File: rtl/cpu_mult_pipe.sv
// Pipelined DATA_W x DATA_W integer multiplier (MUL/MULH/MULHSU/MULHU) with
// valid/ready flow control, a carried tag and a synchronous pipeline flush.
module cpu_mult_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  // Extending to 2*DATA_W bits and keeping the product modulo 2^(2*DATA_W)
  // yields the same bits as the (2*DATA_W+2)-bit signed product we return.
  function automatic logic [DATA_W-1:0] mul_sel(input logic [DATA_W-1:0] s1,
                                                input logic [DATA_W-1:0] s2,
                                                input op_e op);
    logic [2*DATA_W-1:0] a;
    logic [2*DATA_W-1:0] b;
    logic [2*DATA_W-1:0] p;
    logic sx1;
    logic sx2;
    sx1 = ((op == OP_MULH) || (op == OP_MULHSU)) && s1[DATA_W-1];
    sx2 = (op == OP_MULH) && s2[DATA_W-1];
    a = {{DATA_W{sx1}}, s1};
    b = {{DATA_W{sx2}}, s2};
    p = a * b;
    return (op == OP_MUL) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
  endfunction

  // Result registers start at stage 1 when stage 0 is an operand register.
  localparam int unsigned RL = (STAGES == 1) ? 0 : 1;

  logic                adv;
  logic [STAGES-1:0]   vld;
  logic [TAG_W-1:0]    tag_q [STAGES];
  logic [DATA_W-1:0]   res_q [RL:STAGES-1];
  logic [DATA_W-1:0]   m1;
  logic [DATA_W-1:0]   m2;
  op_e                 mop;
  logic [DATA_W-1:0]   res_new;

  assign adv        = ~vld[STAGES-1] | out_ready;
  assign in_ready   = adv & ~flush;
  assign out_valid  = vld[STAGES-1];
  assign out_result = res_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];

  generate
    if (STAGES == 1) begin : g_direct
      assign m1  = in_src1;
      assign m2  = in_src2;
      assign mop = op_e'(in_op);
    end else begin : g_opreg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          m1  <= '0;
          m2  <= '0;
          mop <= OP_MUL;
        end else if (!flush && adv && in_valid) begin
          m1  <= in_src1;
          m2  <= in_src2;
          mop <= op_e'(in_op);
        end
      end
    end
  endgenerate

  assign res_new = mul_sel(m1, m2, mop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int unsigned k = 0; k < STAGES; k++) tag_q[k] <= '0;
      for (int unsigned k = RL; k < STAGES; k++) res_q[k] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      if (in_valid) tag_q[0] <= in_tag;
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld[k]   <= vld[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      // With a single stage the product is taken straight from the operands,
      // so it is only captured on accept.
      if (RL != 0 || in_valid) res_q[RL] <= res_new;
      for (int unsigned k = RL + 1; k < STAGES; k++) res_q[k] <= res_q[k-1];
    end
  end

endmodule
